// File: rtl/program_loader.sv
// Boot loader: fills the code memory from a framed byte stream (length header,
// big-endian words, XOR checksum) and raises run only after a clean load.
module program_loader #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              code_w_en,
    output logic [ADDR_W-1:0] code_addr,
    output logic [WORD_W-1:0] code_data,
    output logic              run,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1 << ADDR_W);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, RUN, ERROR
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [7:0]        chk;
    logic [7:0]        word_hi;
    logic [ADDR_W-1:0] addr;

    logic              accept;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W:0]   wl_next;

    always_comb begin
        rx_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                   (state == DATA_LO) || (state == CHK);
        busy     = rx_ready || (state == WRITE);
        accept   = rx_valid && rx_ready;
        len_full = {len[LEN_W-1:8], rx_data};
        wl_next  = words_loaded + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            len          <= '0;
            chk          <= '0;
            word_hi      <= '0;
            addr         <= '0;
            code_w_en    <= 1'b0;
            code_addr    <= '0;
            code_data    <= '0;
            run          <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            code_w_en <= 1'b0;
            // start wins over any byte accepted in the same cycle
            if (start) begin
                state        <= LEN_HI;
                len          <= '0;
                chk          <= '0;
                addr         <= '0;
                run          <= 1'b0;
                err          <= 1'b0;
                words_loaded <= '0;
            end else begin
                case (state)
                    LEN_HI: if (accept) begin
                        chk <= chk ^ rx_data;
                        if (rx_data[7:LEN_W-8] != '0) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else begin
                            len   <= {rx_data[LEN_W-9:0], 8'h00};
                            state <= LEN_LO;
                        end
                    end
                    LEN_LO: if (accept) begin
                        chk <= chk ^ rx_data;
                        len <= len_full;
                        if (len_full == '0 || len_full > DEPTH) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                    DATA_HI: if (accept) begin
                        chk     <= chk ^ rx_data;
                        word_hi <= rx_data;
                        state   <= DATA_LO;
                    end
                    DATA_LO: if (accept) begin
                        chk       <= chk ^ rx_data;
                        code_w_en <= 1'b1;
                        code_addr <= addr;
                        code_data <= {word_hi, rx_data};
                        state     <= WRITE;
                    end
                    WRITE: begin
                        addr         <= addr + 1'b1;
                        words_loaded <= wl_next;
                        state        <= (wl_next == len) ? CHK : DATA_HI;
                    end
                    CHK: if (accept) begin
                        if (rx_data == chk) begin
                            state <= RUN;
                            run   <= 1'b1;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
                    IDLE, RUN, ERROR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed vector table, reset/abort sequences,
// full-depth load and randomized loads checked against a stream-level model.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst, start, rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic        code_w_en, run, busy, err;
    logic [8:0]  code_addr;
    logic [15:0] code_data;
    logic [9:0]  words_loaded;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .code_w_en(code_w_en), .code_addr(code_addr),
        .code_data(code_data), .run(run), .busy(busy), .err(err),
        .words_loaded(words_loaded)
    );

    int n_cmp = 0, n_bad = 0;
    int gap_max = 0;

    // write-port monitor: captured memory image tagged by load generation
    int dmem[512];
    int wgen[512];
    int gen = 0;
    int wr_total = 0, wr_base = 0, last_wa = -1, ready_viol = 0;

    always @(negedge clk) begin
        if (code_w_en === 1'b1) begin
            wr_total++;
            dmem[code_addr] = int'(code_data);
            wgen[code_addr] = gen;
            last_wa = int'(code_addr);
            if (rx_ready !== 1'b0) ready_viol++;
        end
    end

    function automatic int mem_word(input int a);
        return (wgen[a] == gen) ? dmem[a] : -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        rx_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        gen++;
        wr_base = wr_total;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        while (g > 0 && rx_ready) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
            g--;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; !rx_ready; t++) begin
            if (t >= 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_accept: rx_ready stuck low, byte %0h not taken", b);
                rx_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Stream-level reference: parse header, count words, XOR everything but the last byte
    task automatic model(input logic [7:0] q[$], output int e_run, output int e_err,
                         output int e_wl, output int e_n);
        int len;
        logic [7:0] x;
        e_run = 0; e_err = 0; e_wl = 0;
        if (int'(q[0]) > 3) begin e_err = 1; e_n = 1; return; end
        len = int'(q[0]) * 256 + int'(q[1]);
        if (len == 0 || len > 512) begin e_err = 1; e_n = 2; return; end
        x = 8'h00;
        for (int i = 0; i < 2 + 2 * len; i++) x ^= q[i];
        e_wl = len;
        e_n  = 3 + 2 * len;
        if (q[e_n-1] == x) e_run = 1; else e_err = 1;
    endtask

    task automatic check_load(input string name, input logic [7:0] q[$]);
        int e_run, e_err, e_wl, e_n, bad;
        model(q, e_run, e_err, e_wl, e_n);
        ready_viol = 0;
        do_start();
        for (int i = 0; i < e_n; i++) send_byte(q[i]);
        @(posedge clk); #1;
        chk({name, ".run"}, run, e_run);
        chk({name, ".err"}, err, e_err);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".words_loaded"}, words_loaded, e_wl);
        chk({name, ".writes"}, wr_total - wr_base, e_wl);
        bad = 0;
        for (int i = 0; i < e_wl; i++)
            if (mem_word(i) != int'({q[2+2*i], q[3+2*i]})) bad++;
        chk({name, ".mem_bad_words"}, bad, 0);
        chk({name, ".rx_ready_in_write"}, ready_viol, 0);
    endtask

    typedef struct {
        int         nb;
        logic [7:0] b[8];
        int         e_run, e_err, e_wl, e_wr, w0, w1;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] x;
        int wb;

        tbl[0] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43, 8'h00}, 0, 1, 2, 2, 32'h1234, 32'hABCD};
        tbl[1] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00}, 1, 0, 2, 2, 32'h1234, 32'hABCD};
        tbl[2] = '{2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 0, -1, -1};
        tbl[3] = '{2, '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 0, -1, -1};
        tbl[4] = '{1, '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 0, -1, -1};
        tbl[5] = '{5, '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50, 8'h00, 8'h00, 8'h00}, 1, 0, 1, 1, 32'hBEEF, -1};
        for (int i = 0; i < 512; i++) wgen[i] = -1;

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        chk("reset.flags", {code_w_en, run, busy, err, rx_ready}, 0);
        chk("reset.code_addr", code_addr, 0);
        chk("reset.code_data", code_data, 0);
        chk("reset.words_loaded", words_loaded, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed vectors: bad checksum, then recovery, header errors, 1-word load
        for (int v = 0; v < 6; v++) begin
            do_start();
            chk($sformatf("vec%0d.busy_after_start", v), busy, 1);
            for (int i = 0; i < tbl[v].nb; i++) send_byte(tbl[v].b[i]);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.run", v), run, tbl[v].e_run);
            chk($sformatf("vec%0d.err", v), err, tbl[v].e_err);
            chk($sformatf("vec%0d.busy", v), busy, 0);
            chk($sformatf("vec%0d.words_loaded", v), words_loaded, tbl[v].e_wl);
            chk($sformatf("vec%0d.writes", v), wr_total - wr_base, tbl[v].e_wr);
            chk($sformatf("vec%0d.mem0", v), mem_word(0), tbl[v].w0);
            chk($sformatf("vec%0d.mem1", v), mem_word(1), tbl[v].w1);
        end

        // start from RUN: run drops, load restarts
        do_start();
        chk("restart.run", run, 0);
        chk("restart.busy", busy, 1);
        chk("restart.words_loaded", words_loaded, 0);

        // abort mid-load, with a byte presented on the start cycle that must be dropped
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
        chk("abort.pre_words_loaded", words_loaded, 1);
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        @(posedge clk); #1;
        start = 1'b0; rx_valid = 1'b0;
        gen++; wr_base = wr_total;
        chk("abort.words_loaded", words_loaded, 0);
        chk("abort.busy", busy, 1);
        chk("abort.err", err, 0);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h50);
        @(posedge clk); #1;
        chk("abort.run", run, 1);
        chk("abort.err_after", err, 0);
        chk("abort.mem0", mem_word(0), 32'hBEEF);

        // async reset mid DATA_LO
        do_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
        chk("arst.pre_busy", busy, 1);
        wb = wr_total;
        #2 rst = 1'b1;
        #1;
        chk("arst.flags", {code_w_en, run, busy, err, rx_ready}, 0);
        chk("arst.code_addr", code_addr, 0);
        chk("arst.code_data", code_data, 0);
        chk("arst.words_loaded", words_loaded, 0);
        rx_valid = 1'b1; rx_data = 8'hCD;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("arst.no_write", wr_total - wb, 0);
        chk("arst.idle_ready", rx_ready, 0);
        chk("arst.idle_busy", busy, 0);

        // full depth, word i = i
        q = {8'h02, 8'h00};
        x = 8'h02;
        for (int i = 0; i < 512; i++) begin
            q.push_back(8'(i >> 8)); q.push_back(8'(i));
            x ^= 8'(i >> 8) ^ 8'(i);
        end
        q.push_back(x);
        check_load("full", q);
        chk("full.last_addr", last_wa, 511);

        // randomized loads with backpressure gaps, some with a corrupted checksum
        gap_max = 3;
        for (int r = 0; r < 10; r++) begin
            int len;
            len = int'($urandom_range(24, 1));
            q = {8'(len >> 8), 8'(len)};
            x = 8'(len >> 8) ^ 8'(len);
            for (int i = 0; i < 2 * len; i++) begin
                q.push_back(8'($urandom));
                x ^= q[q.size()-1];
            end
            if (r % 3 == 2) x ^= 8'(int'($urandom_range(255, 1)));
            q.push_back(x);
            check_load($sformatf("rand%0d", r), q);
        end
        check_load("bp_nominal", '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
        chk("bp_nominal.mem1", mem_word(1), 32'hABCD);
        gap_max = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
